// File: rtl/if_stage_if.sv
// Bundle of stall/redirect controls, instruction-ROM port and IF/ID outputs for if_stage.
// master = fetch stage; slave = surrounding pipeline/ROM.
interface if_stage_if;
    localparam int unsigned XLEN = 32;

    logic            stall;
    logic            flush;
    logic [XLEN-1:0] new_pc;
    logic            branch_flag_i;
    logic [XLEN-1:0] branch_target_i;
    logic            rom_ce_o;
    logic [XLEN-1:0] rom_addr_o;
    logic [XLEN-1:0] rom_inst_i;
    logic [XLEN-1:0] id_pc_o;
    logic [XLEN-1:0] id_inst_o;
    logic            id_valid_o;

    modport master (
        input  stall, flush, new_pc, branch_flag_i, branch_target_i, rom_inst_i,
        output rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o
    );

    modport slave (
        output stall, flush, new_pc, branch_flag_i, branch_target_i, rom_inst_i,
        input  rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, ROM drive and IF/ID pipeline register.
// Optional macro IF_DELAY_SLOT_EN: keep the instruction fetched alongside a taken branch (delay slot).
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    if_stage_if.master bus
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic {
        IDLE,
        FETCH
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            valid;
    } id_reg_t;

    localparam id_reg_t ID_RESET = '{pc: '0, inst: '0, valid: 1'b0};

    state_e          state_q, state_d;
    logic            ce_q, ce_d;
    logic [XLEN-1:0] pc_q, pc_d;
    id_reg_t         id_q, id_d;
    id_reg_t         fetched;

    assign fetched = '{pc: pc_q, inst: bus.rom_inst_i, valid: 1'b1};

    // Next-state: flush > stall > branch > sequential fetch.
    always_comb begin
        state_d = state_q;
        ce_d    = ce_q;
        pc_d    = pc_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                ce_d    = 1'b1;
            end
            FETCH: begin
                ce_d = 1'b1;
                if (bus.flush) begin
                    pc_d = bus.new_pc & ALIGN_MASK;
                    id_d = '{pc: '0, inst: NOP_INST, valid: 1'b0};
                end else if (bus.stall) begin
                    pc_d = pc_q;
                    id_d = id_q;
                end else if (bus.branch_flag_i) begin
                    pc_d = bus.branch_target_i & ALIGN_MASK;
`ifdef IF_DELAY_SLOT_EN
                    id_d = fetched;
`else
                    id_d = '{pc: pc_q, inst: NOP_INST, valid: 1'b0};
`endif
                end else begin
                    pc_d = pc_q + PC_STEP;
                    id_d = fetched;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ce_q    <= 1'b0;
            pc_q    <= RESET_PC;
            id_q    <= ID_RESET;
        end else begin
            state_q <= state_d;
            ce_q    <= ce_d;
            pc_q    <= pc_d;
            id_q    <= id_d;
        end
    end

    assign bus.rom_ce_o   = ce_q;
    assign bus.rom_addr_o = pc_q;
    assign bus.id_pc_o    = id_q.pc;
    assign bus.id_inst_o  = id_q.inst;
    assign bus.id_valid_o = id_q.valid;
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the single-issue MIPS core. It owns the program counter, drives the chip-enable and byte address of the combinational instruction ROM, and captures the returned word into the IF/ID pipeline register. The ID stage consumes it. It handles pipeline stall, branch/jump redirect from ID, and exception flush from the control unit.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INST`, default 32'h0000_0000: word injected into ID when a slot is squashed.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous assert, active-low (`rst == 0` resets).
- `stall` in 1: hold PC and IF/ID register.
- `flush` in 1: exception flush from control unit.
- `new_pc` in 32: exception handler address, used with `flush`.
- `branch_flag_i` in 1: taken branch/jump resolved in ID.
- `branch_target_i` in 32: redirect address.
- `rom_ce_o` out 1: ROM chip enable, high = enabled.
- `rom_addr_o` out 32: ROM byte address; always equals the PC register.
- `rom_inst_i` in 32: instruction word, valid in the same cycle as `rom_addr_o`.
- `id_pc_o` out 32: PC of the instruction presented to ID.
- `id_inst_o` out 32: instruction presented to ID.
- `id_valid_o` out 1: `id_inst_o` is a real fetched instruction.

## Operation
- Two-state FSM:
  - `IDLE`: entered on reset. Drives `rom_ce_o`=0 and holds PC at `RESET_PC`. Moves to `FETCH` on the first clock edge after `rst` deasserts.
  - `FETCH`: drives `rom_ce_o`=1. Stays here until reset.
- Reset values: pc=`RESET_PC`, `rom_ce_o`=0, `id_pc_o`=0, `id_inst_o`=0, `id_valid_o`=0.
- Action on each edge in `FETCH`, highest priority first:
  1. `flush`: pc<=`new_pc`; ID register <= {pc 0, `NOP_INST`, valid 0}.
  2. `stall`: pc and ID register hold. `branch_flag_i` is ignored; ID re-asserts it after the stall.
  3. `branch_flag_i`: pc<=`branch_target_i`. The ID register takes the current fetch according to the configuration below.
  4. Otherwise: pc<=pc+4; ID register <= {pc, `rom_inst_i`, 1}.
- Width and arithmetic rules:
  - PC bits [1:0] are forced to 0 on every load; bits [1:0] of `new_pc` and `branch_target_i` are ignored.
  - pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a clock edge. The instruction in flight is dropped.

## Timing
- ROM is combinational, so fetch latency is 1 cycle: the word at address A appears on `id_inst_o` on the edge after `rom_addr_o`=A.
- The first valid ID output comes 2 edges after `rst` deasserts: edge 1 performs IDLE→FETCH, edge 2 captures `RESET_PC`.
- Redirect penalty:
  - With delay slot: 0 bubbles after the delay slot.
  - Without delay slot: 1 bubble.
- Flush penalty: 1 bubble, after which the `new_pc` fetch is captured.
- `stall` and `flush` in the same cycle: flush wins.
- `branch_flag_i` and `stall` in the same cycle: nothing changes.

## Configuration
- `IF_DELAY_SLOT_EN` defined:
  - On a taken branch, the instruction currently being fetched (at pc) is the architectural delay slot.
  - It is latched normally: {pc, `rom_inst_i`, 1}.
- `IF_DELAY_SLOT_EN` undefined:
  - That instruction is squashed: ID register <= {pc, `NOP_INST`, 0}.
  - The target is fetched next.

## Test plan
- Reset then release, no stall: edge 1 gives `rom_ce_o`=1, addr 0. Edge 2 gives `id_pc_o`=0, `id_valid_o`=1. Then addr advances 4, 8, 12, …
- Stall held 3 cycles at addr 0x10: `rom_addr_o` stays 0x10 and the ID outputs stay constant. Once stall is released, the next edge captures 0x10 and addr becomes 0x14.
- Branch asserted at pc=0x20 with target 0x103:
  - Next addr = 0x100.
  - With `IF_DELAY_SLOT_EN`: ID gets pc 0x20 with valid 1.
  - Without it: ID gets `NOP_INST` with valid 0.
- `flush` and `stall` together with `new_pc`=0x180: next addr = 0x180, `id_valid_o`=0, `id_inst_o`=0.
- Branch to 0xFFFF_FFFC, then no stall: addr sequence is 0xFFFF_FFFC then 0x0.
- Assert `rst`=0 mid-cycle while in `FETCH`: `rom_ce_o`, `id_valid_o` and `id_inst_o` go to 0 and addr goes to `RESET_PC` before the next edge.
